// File: rtl/dispatch_controller.sv
// dispatch_controller: pops the gate-model head, offers it to a field unit with valid/ack,
// applies an inter-dispatch cooldown and keeps saturating served/timeout statistics.
module dispatch_controller #(
  parameter int COOLDOWN    = 4,
  parameter int ACK_TIMEOUT = 32,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_stats,
  input  logic             evac_empty,
  input  logic             shelter_valid,
  input  logic             food_valid,
  input  logic             head_is_shelter,
  input  logic [7:0]       head_zone,
  input  logic [1:0]       head_priority,
  input  logic             unit_ready,
  input  logic             unit_ack,
  output logic             serve,
  output logic             dispatch_valid,
  output logic [7:0]       dispatch_zone,
  output logic [1:0]       dispatch_priority,
  output logic [1:0]       dispatch_type,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] served_evac,
  output logic [CNT_W-1:0] served_shelter,
  output logic [CNT_W-1:0] served_food,
  output logic [CNT_W-1:0] timeout_count
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int CW = $clog2(COOLDOWN + 2);
  typedef enum logic [1:0] {IDLE, OFFER, COOL} state_t;
  state_t          state;
  logic [TW-1:0]   timer;
  logic [CW-1:0]   cool;
  logic            work;
  logic            ack;
  logic [1:0]      head_type;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
  always_comb begin
    work        = !evac_empty | shelter_valid | food_valid;
    head_type   = !evac_empty ? 2'b10 : (head_is_shelter & shelter_valid) ? 2'b01 : food_valid ? 2'b00 : 2'b01;
    serve       = rst_n & (state == IDLE) & enable & work & unit_ready;
    ack         = (state == OFFER) & unit_ack;
    timeout_err = (state == OFFER) & !unit_ack & (timer == TW'(ACK_TIMEOUT - 1));
    busy        = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      timer             <= '0;
      cool              <= '0;
      dispatch_valid    <= 1'b0;
      dispatch_zone     <= '0;
      dispatch_priority <= '0;
      dispatch_type     <= '0;
      served_evac       <= '0;
      served_shelter    <= '0;
      served_food       <= '0;
      timeout_count     <= '0;
    end else begin
      case (state)
        IDLE: if (serve) begin
          state             <= OFFER;
          dispatch_valid    <= 1'b1;
          dispatch_zone     <= head_zone;
          dispatch_priority <= head_priority;
          dispatch_type     <= head_type;
          timer             <= '0;
        end
        OFFER: if (unit_ack) begin
          dispatch_valid <= 1'b0;
          cool           <= '0;
          state          <= (COOLDOWN == 0) ? IDLE : COOL;
        end else begin
          timer <= timeout_err ? '0 : timer + 1'b1;
        end
        COOL: if (cool == CW'(COOLDOWN - 1)) state <= IDLE;
              else cool <= cool + 1'b1;
        default: state <= IDLE;
      endcase
      // a clear in the same cycle as an increment leaves the counter at zero
      if (clr_stats) begin
        served_evac    <= '0;
        served_shelter <= '0;
        served_food    <= '0;
        timeout_count  <= '0;
      end else begin
        if (ack && dispatch_type == 2'b10) served_evac <= sat_inc(served_evac);
        if (ack && dispatch_type == 2'b01) served_shelter <= sat_inc(served_shelter);
        if (ack && dispatch_type == 2'b00) served_food <= sat_inc(served_food);
        if (timeout_err) timeout_count <= sat_inc(timeout_count);
      end
    end
  end
endmodule
